fifo_control: RTL and testbench

Pointer and flag controller for a router input-buffer FIFO. It accepts PUSH/POP requests from the link and crossbar sides and tracks occupancy. It drives the write strobe, write address and read address of the buffer's storage array: synchronous write port, asynchronous read port, `BUFFER_DEPTH` entries of `CHANNEL_WIDTH` bits. It sits directly upstream of that array and raises the full/empty flags used by link flow control and the router arbiter.

---
 rtl/fifo_control.sv | 97 +++++++++
 tb/tb_fifo_control.sv | 138 +++++++++++++
 2 files changed

// File: rtl/fifo_control.sv
// fifo_control: pointer and flag controller for a router input-buffer FIFO.
// It drives the write strobe and the write/read addresses of an external
// storage array (synchronous write, asynchronous read). It also keeps the
// occupancy count and the registered full/empty flags used by link flow
// control and the arbiter.
//
// Ports:
//   clk                 clock, all state updates on the rising edge
//   reset               synchronous, active-high
//   push_din            push request (flit on the storage write-data bus)
//   pop_din             pop request (consumer took the head flit)
//   write_strobe_dout   storage write enable, combinational (push accepted)
//   write_address_dout  write pointer, registered
//   read_address_dout   read pointer (head entry), registered
//   full_dout           registered, occupancy == BUFFER_DEPTH
//   empty_dout          registered, occupancy == 0
//   count_dout          registered occupancy, 0..BUFFER_DEPTH
`ifndef BUFFER_DEPTH
`define BUFFER_DEPTH 4
`endif

module fifo_control #(
  parameter int BUFFER_DEPTH = `BUFFER_DEPTH
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                push_din,
  input  logic                                pop_din,
  output logic                                write_strobe_dout,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0]   write_address_dout,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0]   read_address_dout,
  output logic                                full_dout,
  output logic                                empty_dout,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0]   count_dout
);

  // Wide enough to hold the count value BUFFER_DEPTH itself.
  localparam int ADDR_WIDTH = $clog2(BUFFER_DEPTH+1);
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(BUFFER_DEPTH-1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH = ADDR_WIDTH'(BUFFER_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ONE   = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wp_q, wp_d;
  logic [ADDR_WIDTH-1:0] rp_q, rp_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  pop_ok, push_ok;

  // A pop on a full buffer frees a slot for a same-cycle push. A pop on an
  // empty buffer is always rejected, so a push is never bypassed to the read side.
  // The strobe is masked during reset so stale data is never written.
  assign pop_ok  = pop_din & ~empty_q;
  assign push_ok = push_din & (~full_q | pop_ok) & ~reset;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    // Explicit wrap, since the depth need not be a power of two.
    if (push_ok) wp_d = (wp_q == LAST) ? '0 : wp_q + ONE;
    if (pop_ok)  rp_d = (rp_q == LAST) ? '0 : rp_q + ONE;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + ONE;
      2'b01:   cnt_d = cnt_q - ONE;
      default: cnt_d = cnt_q;
    endcase
    // Flags come from the next count, so they are registered with no
    // combinational path from the requests.
    full_d  = (cnt_d == DEPTH);
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign write_strobe_dout  = push_ok;
  assign write_address_dout = wp_q;
  assign read_address_dout  = rp_q;
  assign full_dout          = full_q;
  assign empty_dout         = empty_q;
  assign count_dout         = cnt_q;

endmodule

// File: tb/tb_fifo_control.sv
// Testbench for fifo_control (BUFFER_DEPTH = 4): a directed vector table
// covering reset, fill, overflow, full push+pop, empty push+pop and reset
// mid-operation, then an oscillation run and random traffic checked against
// a queue-based reference model with a data scoreboard.
module tb_fifo_control;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       push_din, pop_din;
  logic       write_strobe_dout;
  logic [2:0] write_address_dout, read_address_dout, count_dout;
  logic       full_dout, empty_dout;

  fifo_control #(.BUFFER_DEPTH(D)) dut (
    .clk                (clk),
    .reset              (reset),
    .push_din           (push_din),
    .pop_din            (pop_din),
    .write_strobe_dout  (write_strobe_dout),
    .write_address_dout (write_address_dout),
    .read_address_dout  (read_address_dout),
    .full_dout          (full_dout),
    .empty_dout         (empty_dout),
    .count_dout         (count_dout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- directed vectors ----------------
  // Expected values are the outputs seen during the cycle the inputs are applied
  // (before the edge that consumes them).
  typedef struct {
    logic push, pop, rst;
    logic s; int wa, ra, c; logic f, e;
  } vec_t;

  vec_t tbl[19];

  task automatic apply_vec(input int i);
    push_din = tbl[i].push; pop_din = tbl[i].pop; reset = tbl[i].rst;
    @(negedge clk);
    check($sformatf("v%0d strobe", i), write_strobe_dout, tbl[i].s);
    check($sformatf("v%0d waddr", i),  write_address_dout, tbl[i].wa);
    check($sformatf("v%0d raddr", i),  read_address_dout, tbl[i].ra);
    check($sformatf("v%0d count", i),  count_dout, tbl[i].c);
    check($sformatf("v%0d full", i),   full_dout, tbl[i].f);
    check($sformatf("v%0d empty", i),  empty_dout, tbl[i].e);
    @(posedge clk); #1;
  endtask

  // ---------------- reference model ----------------
  int          m_cnt, m_wp, m_rp;
  logic [15:0] q[$];
  logic [15:0] mem[0:7];
  logic [15:0] din;

  task automatic step(input logic psh, input logic pp, input logic rst);
    logic exp_pop, exp_push;
    logic [15:0] head;
    push_din = psh; pop_din = pp; reset = rst; din = 16'($urandom);
    @(negedge clk);
    exp_pop  = pp && (m_cnt > 0);
    exp_push = psh && !rst && (m_cnt < D || exp_pop);
    check("rnd strobe", write_strobe_dout, exp_push);
    check("rnd waddr",  write_address_dout, m_wp);
    check("rnd raddr",  read_address_dout, m_rp);
    check("rnd count",  count_dout, m_cnt);
    check("rnd full",   full_dout, m_cnt == D);
    check("rnd empty",  empty_dout, m_cnt == 0);
    check("rnd not_both", full_dout & empty_dout, 0);
    // Asynchronous read of the head happens before this edge's write.
    if (exp_pop && !rst && q.size() > 0) begin
      head = q.pop_front();
      check("rnd head_data", mem[read_address_dout], head);
    end
    if (write_strobe_dout) mem[write_address_dout] = din;
    if (exp_push) q.push_back(din);
    @(posedge clk); #1;
    if (rst) begin
      m_cnt = 0; m_wp = 0; m_rp = 0; q.delete();
    end else begin
      m_cnt = m_cnt + int'(exp_push) - int'(exp_pop);
      m_wp  = (m_wp + int'(exp_push)) % D;
      m_rp  = (m_rp + int'(exp_pop)) % D;
    end
  endtask

  initial begin
    //         push pop rst  s  wa ra c  f  e
    tbl[0]  = '{0, 0, 0,    0, 0, 0, 0, 0, 1};  // idle after reset
    tbl[1]  = '{1, 0, 0,    1, 0, 0, 0, 0, 1};
    tbl[2]  = '{1, 0, 0,    1, 1, 0, 1, 0, 0};
    tbl[3]  = '{1, 0, 0,    1, 2, 0, 2, 0, 0};
    tbl[4]  = '{1, 0, 0,    1, 3, 0, 3, 0, 0};
    tbl[5]  = '{1, 0, 0,    0, 0, 0, 4, 1, 0};  // 5th push rejected
    tbl[6]  = '{0, 0, 0,    0, 0, 0, 4, 1, 0};  // wp/cnt unchanged
    tbl[7]  = '{1, 1, 0,    1, 0, 0, 4, 1, 0};  // full push+pop
    tbl[8]  = '{0, 0, 0,    0, 1, 1, 4, 1, 0};
    tbl[9]  = '{0, 1, 0,    0, 1, 1, 4, 1, 0};
    tbl[10] = '{0, 1, 0,    0, 1, 2, 3, 0, 0};
    tbl[11] = '{0, 1, 0,    0, 1, 3, 2, 0, 0};
    tbl[12] = '{0, 1, 0,    0, 1, 0, 1, 0, 0};  // rp wrapped 3->0
    tbl[13] = '{1, 1, 0,    1, 1, 1, 0, 0, 1};  // empty push+pop
    tbl[14] = '{1, 0, 0,    1, 2, 1, 1, 0, 0};  // pop was rejected
    tbl[15] = '{1, 0, 0,    1, 3, 1, 2, 0, 0};
    tbl[16] = '{0, 0, 0,    0, 0, 1, 3, 0, 0};
    tbl[17] = '{1, 0, 1,    0, 0, 1, 3, 0, 0};  // reset + push, cnt=3
    tbl[18] = '{0, 0, 0,    0, 0, 0, 0, 0, 1};  // cleared

    reset = 1'b1; push_din = 1'b0; pop_din = 1'b0; din = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 19; i++) apply_vec(i);

    // Oscillation 1<->2 across pointer wrap, with the data scoreboard.
    step(0, 0, 1);
    step(1, 0, 0);
    for (int i = 0; i < 10; i++) step(i % 2 == 0, i % 2 == 1, 0);

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 60) == 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
